// File: rtl/multi_cond_sequencer.sv
// multi_cond_sequencer
//   Collects arrivals on N_CH condition inputs, remembers which channel
//   arrived first, and once every channel has been seen and go is asserted
//   runs a timed two-phase actuation (ACT1 then ACT2) before parking in DONE.
//   COLLECT has a timeout into ERR. clear is a synchronous abort to IDLE.
//
//   Optional feature macro: SEQ_STRICT_ORDER_EN
//     When defined, a channel may newly set only if every lower-index channel
//     is already seen or sets in the same cycle; a violation goes to ERR.
//
// Parameters
//   N_CH        number of condition channels (2..8)
//   HOLD_CYC    cycles spent in each actuation phase (>=1)
//   TIMEOUT_CYC maximum cycles allowed in COLLECT (1..65535)
//   IDXW        derived index width, $clog2(N_CH)
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   cond      per-channel condition inputs
//   go        start request, honoured only in READY
//   clear     synchronous abort to IDLE
//   ch_seen   sticky per-channel seen flags
//   first_ch  index of first channel to arrive
//   ready     high in READY
//   act       actuator enable, high in ACT1/ACT2
//   phase     00 idle/collect/ready/err, 01 ACT1, 10 ACT2, 11 DONE
//   err       high in ERR
module multi_cond_sequencer #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned IDXW       = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] cond,
  input  logic            go,
  input  logic            clear,
  output logic [N_CH-1:0] ch_seen,
  output logic [IDXW-1:0] first_ch,
  output logic            ready,
  output logic            act,
  output logic [1:0]      phase,
  output logic            err
);

  localparam int unsigned HOLDW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned TMOW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StReady,
    StAct1,
    StAct2,
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   seen_q, seen_d;
  logic [IDXW-1:0]   first_q, first_d;
  logic [TMOW-1:0]   tmo_q, tmo_d;
  logic [HOLDW-1:0]  hold_q, hold_d;

  logic [N_CH-1:0]   nseen;
  logic              all_seen;
  logic              order_viol;

  // Lowest set index wins on simultaneous arrival.
  function automatic logic [IDXW-1:0] lowest_idx(input logic [N_CH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  assign nseen    = seen_q | cond;
  assign all_seen = (nseen == {N_CH{1'b1}});

`ifdef SEQ_STRICT_ORDER_EN
  // A newly arriving channel is legal only if every lower channel is in nseen.
  always_comb begin
    logic prefix_ok;
    order_viol = 1'b0;
    prefix_ok  = 1'b1;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (cond[k] && !seen_q[k] && !prefix_ok) order_viol = 1'b1;
      prefix_ok = prefix_ok & nseen[k];
    end
  end
`else
  assign order_viol = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    first_d = first_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    if (clear) begin
      state_d = StIdle;
      seen_d  = '0;
      first_d = '0;
      tmo_d   = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          seen_d = nseen;
          if (cond != '0) first_d = lowest_idx(cond);
          if (order_viol) begin
            state_d = StErr;
          end else if (all_seen) begin
            state_d = StReady;
          end else if (cond != '0) begin
            state_d = StCollect;
            tmo_d   = '0;
          end
        end
        StCollect: begin
          seen_d = nseen;
          // Completion beats timeout; an order violation beats completion.
          if (order_viol) begin
            state_d = StErr;
          end else if (all_seen) begin
            state_d = StReady;
          end else if (tmo_q == TMOW'(TIMEOUT_CYC - 1)) begin
            state_d = StErr;
          end else begin
            tmo_d = tmo_q + TMOW'(1);
          end
        end
        StReady: begin
          if (go) begin
            state_d = StAct1;
            hold_d  = '0;
          end
        end
        StAct1: begin
          if (hold_q == HOLDW'(HOLD_CYC - 1)) begin
            state_d = StAct2;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLDW'(1);
          end
        end
        StAct2: begin
          if (hold_q == HOLDW'(HOLD_CYC - 1)) begin
            state_d = StDone;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLDW'(1);
          end
        end
        default: ;  // DONE and ERR are terminal
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      seen_q  <= '0;
      first_q <= '0;
      tmo_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      first_q <= first_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
    end
  end

  // Moore outputs; reset state decodes to all-zero so reset acts immediately.
  assign ch_seen  = seen_q;
  assign first_ch = first_q;
  assign ready    = (state_q == StReady);
  assign act      = (state_q == StAct1) || (state_q == StAct2);
  assign err      = (state_q == StErr);

  always_comb begin
    phase = 2'b00;
    unique case (state_q)
      StAct1:  phase = 2'b01;
      StAct2:  phase = 2'b10;
      StDone:  phase = 2'b11;
      default: phase = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multi_cond_sequencer.sv
// Testbench for multi_cond_sequencer (N_CH=4, HOLD_CYC=3, TIMEOUT_CYC=10).
// Directed scenarios plus randomized stimulus, every cycle compared against
// a timeline-based reference model.
module tb_multi_cond_sequencer;

  localparam int NCH  = 4;
  localparam int HOLD = 3;
  localparam int TMO  = 10;

  // Model modes: what the block is doing, not how it is encoded.
  localparam int MIdle    = 0;
  localparam int MCollect = 1;
  localparam int MReady   = 2;
  localparam int MRun     = 3;
  localparam int MErr     = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] cond  = '0;
  logic           go    = 1'b0;
  logic           clear = 1'b0;
  logic [NCH-1:0] ch_seen;
  logic [1:0]     first_ch;
  logic           ready;
  logic           act;
  logic [1:0]     phase;
  logic           err;

  int n_checks = 0;
  int n_pass   = 0;

  int             m_mode;
  int             m_cnt;
  logic [NCH-1:0] m_seen;
  int             m_first;

  multi_cond_sequencer #(
    .N_CH        (NCH),
    .HOLD_CYC    (HOLD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cond     (cond),
    .go       (go),
    .clear    (clear),
    .ch_seen  (ch_seen),
    .first_ch (first_ch),
    .ready    (ready),
    .act      (act),
    .phase    (phase),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic int lowest(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 0;
  endfunction

  // True if some newly arriving channel has a missing lower channel.
  function automatic bit strict_bad(input logic [NCH-1:0] seen, input logic [NCH-1:0] c);
    logic [NCH-1:0] ns;
    ns = seen | c;
    for (int k = 0; k < NCH; k++) begin
      if (c[k] && !seen[k]) begin
        for (int j = 0; j < k; j++) if (!ns[j]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode  = MIdle;
    m_cnt   = 0;
    m_seen  = '0;
    m_first = 0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] ns;
    bit             bad;
    if (clear) begin
      model_reset();
      return;
    end
    case (m_mode)
      MIdle, MCollect: begin
        ns  = m_seen | cond;
        bad = 1'b0;
`ifdef SEQ_STRICT_ORDER_EN
        bad = strict_bad(m_seen, cond);
`endif
        if (m_mode == MIdle && cond != '0) m_first = lowest(cond);
        m_seen = ns;
        if (bad) m_mode = MErr;
        else if (&ns) m_mode = MReady;
        else if (m_mode == MIdle) begin
          if (cond != '0) begin
            m_mode = MCollect;
            m_cnt  = 0;
          end
        end else begin
          m_cnt++;
          if (m_cnt >= TMO) m_mode = MErr;
        end
      end
      MReady: if (go) begin
        m_mode = MRun;
        m_cnt  = 0;
      end
      MRun: if (m_cnt < 2 * HOLD) m_cnt++;
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    logic [1:0] e_phase;
    logic       e_act;
    e_act   = (m_mode == MRun) && (m_cnt < 2 * HOLD);
    e_phase = (m_mode != MRun) ? 2'b00 : (m_cnt < HOLD) ? 2'b01 : (m_cnt < 2 * HOLD) ? 2'b10 : 2'b11;
    check("ch_seen", 32'(ch_seen), 32'(m_seen));
    check("first_ch", 32'(first_ch), 32'(m_first));
    check("ready", 32'(ready), 32'(m_mode == MReady));
    check("act", 32'(act), 32'(e_act));
    check("phase", 32'(phase), 32'(e_phase));
    check("err", 32'(err), 32'(m_mode == MErr));
  endtask

  task automatic cycle(input logic [NCH-1:0] c, input logic g, input logic cl);
    cond  = c;
    go    = g;
    clear = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    int act_cnt;
    int waited;
    model_reset();

    // Reset held with random inputs: everything stays at reset values.
    for (int i = 0; i < 4; i++) begin
      cond  = NCH'($urandom);
      go    = 1'($urandom);
      clear = 1'($urandom);
      #7;
      check_outputs();
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle('0, 1'b0, 1'b0);

    // Normal flow: 4,1,8,2 then go.
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    check("ready_early", 32'(ready), 32'd0);
    cycle(4'b0010, 1'b0, 1'b0);
    check("ready_norm", 32'(ready), 32'd1);
    check("first_norm", 32'(first_ch), 32'd2);
    cycle('0, 1'b1, 1'b0);
    act_cnt = act ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      cycle('0, 1'b0, 1'b0);
      if (act) act_cnt++;
    end
    check("act_len", 32'(act_cnt), 32'(2 * HOLD));
    check("done_phase", 32'(phase), 32'd3);
    cycle('0, 1'b1, 1'b1);

    // Timeout: single channel, err visible after TMO further edges.
    cycle(4'b0001, 1'b0, 1'b0);
    waited = 0;
    while (!err && waited < 30) begin
      cycle('0, 1'b0, 1'b0);
      waited++;
    end
    check("timeout_edges", 32'(waited), 32'(TMO));
    check("timeout_seen", 32'(ch_seen), 32'h1);
    cycle('0, 1'b0, 1'b1);
    check("clear_err", 32'(err), 32'd0);
    check("clear_seen", 32'(ch_seen), 32'd0);

    // Simultaneous arrival from IDLE.
    cycle(4'b1111, 1'b0, 1'b0);
    check("simul_ready", 32'(ready), 32'd1);
    check("simul_first", 32'(first_ch), 32'd0);
    cycle('0, 1'b0, 1'b1);
    // go in COLLECT is ignored.
    cycle(4'b0001, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    cycle(4'b1110, 1'b1, 1'b0);
    check("go_ignored", 32'(ready), 32'd1);

    // Async reset mid-ACT2.
    cycle('0, 1'b1, 1'b0);
    for (int i = 0; i < HOLD + 1; i++) cycle('0, 1'b0, 1'b0);
    check("in_act2", 32'(phase), 32'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_act", 32'(act), 32'd0);
    check("arst_phase", 32'(phase), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b1100, 1'b0, 1'b0);
    check("post_rst_ready", 32'(ready), 32'd1);
    cycle('0, 1'b0, 1'b1);

    // Order sensitivity.
    cycle(4'b0010, 1'b0, 1'b0);
`ifdef SEQ_STRICT_ORDER_EN
    check("strict_err", 32'(err), 32'd1);
`else
    check("loose_err", 32'(err), 32'd0);
    check("loose_first", 32'(first_ch), 32'd1);
`endif
    cycle('0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [NCH-1:0] c;
      c = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      cycle(c, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cond_sequencer.md
# multi_cond_sequencer

Parametrised condition-collection and actuation sequencer for tile-level control designs. It collects arrivals on `N_CH` condition inputs and records which channel arrived first. Once every channel has been seen and `go` is asserted, it runs a timed two-phase actuation (A, then B) and parks in DONE. It adds a collection timeout, a synchronous abort and optional strict-order checking, and sits directly between `io_in` condition pins and `io_out` actuator pins of a `tt_um_*` top.

## Interface
- `N_CH`, 4: number of condition channels, legal range 2..8.
- `HOLD_CYC`, 4: cycles spent in each actuation phase, ≥1.
- `TIMEOUT_CYC`, 255: maximum cycles allowed in COLLECT, ≥1, ≤65535.
- `IDXW`, derived: $clog2(N_CH); not user-set.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cond`  in  N_CH  condition pulses or levels; sampled every cycle.
- `go`  in  1  start request; sampled only in READY.
- `clear`  in  1  synchronous abort to IDLE; overrides everything except `rst_n`.
- `ch_seen`  out  N_CH  sticky per-channel seen flags.
- `first_ch`  out  IDXW  index of the first channel to arrive.
- `ready`  out  1  high in READY.
- `act`  out  1  actuator enable; high in ACT1 and ACT2.
- `phase`  out  2  00 = IDLE/COLLECT/READY/ERR, 01 = ACT1, 10 = ACT2, 11 = DONE.
- `err`  out  1  high in ERR.

## Operation
- States: IDLE, COLLECT, READY, ACT1, ACT2, DONE, ERR. Encoding is free.
- Reset values: state IDLE, `ch_seen`=0, `first_ch`=0, `ready`=0, `act`=0, `phase`=00, `err`=0. Internal counters are 0.
- `nseen = ch_seen | cond`. It is evaluated in IDLE and COLLECT only. `ch_seen` <= `nseen` in those states and is frozen in all other states.
- IDLE:
  - `nseen` all ones → READY.
  - Else `cond`≠0 → COLLECT.
  - Else stay.
  - On leaving IDLE, `first_ch` <= lowest set index of `cond`; lowest index wins on simultaneous arrival.
- COLLECT:
  - `nseen` all ones → READY.
  - Else timeout counter == TIMEOUT_CYC−1 → ERR.
  - Else increment the counter.
  - The counter is zeroed on entry. Completion beats timeout in the same cycle.
- READY: `go`=1 → ACT1, with the hold counter zeroed. `go` is ignored in every other state.
- ACT1 / ACT2: each lasts exactly HOLD_CYC cycles, then ACT1 → ACT2 → DONE.
- DONE and ERR are terminal; only `clear` or reset leaves them.
- `clear`=1 in any state:
  - next state IDLE;
  - `ch_seen`, `first_ch` and both counters zeroed;
  - `cond` in the same cycle is ignored.
- All outputs are Moore, decoded from registered state and flags. No combinational input→output path.

## Timing
- `cond` bit k high at edge t → `ch_seen[k]`=1 from t+1.
- The last missing channel arrives at edge t → `ready`=1 from t+1, even if all channels arrive in the same cycle from IDLE.
- `go` sampled high at edge t in READY → `act`=1 and `phase`=01 for cycles t+1..t+HOLD_CYC.
- `phase`=10 for the next HOLD_CYC cycles.
- `phase`=11 and `act`=0 from t+1+2·HOLD_CYC.
- COLLECT entered at edge t with no completion → `err`=1 from t+TIMEOUT_CYC+1.
- `rst_n` low at any time, including mid-actuation: all outputs reach reset values immediately, without waiting for a clock.
- Reset release is synchronous to `clk`; the first state update is on the first rising edge with `rst_n`=1.

## Configuration
- Macro `SEQ_STRICT_ORDER_EN`:
  - Defined: a channel may newly set only if all lower-index channels are already seen or set in the same cycle. A violation in IDLE or COLLECT → ERR at that edge; `ch_seen` still updates. Completion does not override a violation.
  - Undefined: arrival order is unrestricted and no ordering logic is synthesised.

## Test plan
All scenarios use N_CH=4, HOLD_CYC=3, TIMEOUT_CYC=10.
- Reset check: hold `rst_n`=0 with random inputs → all outputs 0 and `phase`=00. Release, then idle 5 cycles with `cond`=0 → outputs unchanged.
- Normal flow, macro undefined:
  - Stimulus: `cond` one-hot 4, 1, 8, 2 on consecutive cycles, then `go`.
  - Required: `first_ch`=2; `ready` the cycle after the `cond`=2 pulse; `act` high for 6 cycles; `phase` 01×3, then 10×3, then 11 held.
- Timeout: only `cond`=0001 → `err`=1 exactly 11 cycles after that edge and `ch_seen`=0001. Then `clear` for one cycle → IDLE with `ch_seen`=0 and `err`=0 the next cycle.
- Simultaneous arrival: `cond`=1111 for one cycle from IDLE → `ready`=1 the next cycle and `first_ch`=0. Drive `go`=1 in COLLECT beforehand → it is ignored.
- Asynchronous reset mid-operation: assert `rst_n`=0 mid-ACT2, between clock edges → `act`=0 and `phase`=00 immediately. After release the block behaves as freshly reset.
- Strict order: with the macro defined, `cond`=0010 first → `err`=1 next cycle. With the macro undefined, the same stimulus → COLLECT with `first_ch`=1.
